// File: rtl/matrix_loader_if.sv
// Bundle of the loader's config, element-stream and result-bus signals.
// The loader takes the slave view; the producer/consumer side takes master.
interface matrix_loader_if #(
  parameter int MAX_SIZE   = 10,
  parameter int DATA_WIDTH = 32
);
  logic                                    cfg_valid;
  logic [31:0]                             cfg_size;
  logic                                    cfg_ready;
  logic                                    cfg_err;
  logic                                    in_valid;
  logic [DATA_WIDTH-1:0]                   in_data;
  logic                                    in_ready;
  logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] A;
  logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] B;
  logic [31:0]                             matrix_size;
  logic                                    out_valid;
  logic                                    out_ack;

  modport master (
    output cfg_valid, cfg_size, in_valid, in_data, out_ack,
    input  cfg_ready, cfg_err, in_ready, A, B, matrix_size, out_valid
  );

  modport slave (
    input  cfg_valid, cfg_size, in_valid, in_data, out_ack,
    output cfg_ready, cfg_err, in_ready, A, B, matrix_size, out_valid
  );
endinterface

// File: rtl/matrix_loader.sv
// Serial-to-parallel feeder for the matrix multiplier: takes a size, then n*n
// A elements and n*n B elements row-major, and presents them as flat buses.
module matrix_loader #(
  parameter int MAX_SIZE   = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  matrix_loader_if.slave bus
);
  localparam int ELEMS = MAX_SIZE * MAX_SIZE;
  localparam int CW    = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD_A = 2'd1;
  localparam logic [1:0] ST_LOAD_B = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [31:0]           size_q, size_d;
  logic                  cfg_err_q, cfg_err_d;
  logic [DATA_WIDTH-1:0] a_q [ELEMS];
  logic [DATA_WIDTH-1:0] a_d [ELEMS];
  logic [DATA_WIDTH-1:0] b_q [ELEMS];
  logic [DATA_WIDTH-1:0] b_d [ELEMS];

  logic cfg_ok;
  logic col_last;
  logic row_last;
  logic clear_mats;
  logic we_a;
  logic we_b;

  assign cfg_ok   = (bus.cfg_size != 32'd0) && (bus.cfg_size <= 32'(MAX_SIZE));
  // size_q is at least 1 whenever the counters are in use, so n-1 never wraps.
  assign col_last = (32'(col_q) == (size_q - 32'd1));
  assign row_last = (32'(row_q) == (size_q - 32'd1));
  assign we_a     = (state_q == ST_LOAD_A) && bus.in_valid;
  assign we_b     = (state_q == ST_LOAD_B) && bus.in_valid;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    size_d     = size_q;
    cfg_err_d  = 1'b0;
    clear_mats = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_valid) begin
          if (cfg_ok) begin
            size_d     = bus.cfg_size;
            clear_mats = 1'b1;
            row_d      = '0;
            col_d      = '0;
            state_d    = ST_LOAD_A;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_LOAD_A, ST_LOAD_B: begin
        if (bus.in_valid) begin
          if (col_last) begin
            col_d = '0;
            if (row_last) begin
              row_d   = '0;
              state_d = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_DONE;
            end else begin
              row_d = row_q + CW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One write-enable decode per element; positions outside n x n never match.
  generate
    for (genvar gi = 0; gi < ELEMS; gi++) begin : g_elem
      localparam logic [CW-1:0] ROW = CW'(gi / MAX_SIZE);
      localparam logic [CW-1:0] COL = CW'(gi % MAX_SIZE);
      logic sel;
      assign sel     = (row_q == ROW) && (col_q == COL);
      assign a_d[gi] = clear_mats ? '0 : ((we_a && sel) ? bus.in_data : a_q[gi]);
      assign b_d[gi] = clear_mats ? '0 : ((we_b && sel) ? bus.in_data : b_q[gi]);
      assign bus.A[gi*DATA_WIDTH +: DATA_WIDTH] = a_q[gi];
      assign bus.B[gi*DATA_WIDTH +: DATA_WIDTH] = b_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      size_q    <= '0;
      cfg_err_q <= 1'b0;
      for (int k = 0; k < ELEMS; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      size_q    <= size_d;
      cfg_err_q <= cfg_err_d;
      for (int k = 0; k < ELEMS; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
      end
    end
  end

  assign bus.cfg_ready   = (state_q == ST_IDLE);
  assign bus.in_ready    = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
  assign bus.out_valid   = (state_q == ST_DONE);
  assign bus.cfg_err     = cfg_err_q;
  assign bus.matrix_size = size_q;
endmodule

// File: doc/matrix_loader.md
# matrix_loader

Upstream feeder for the combinational parallel matrix multiplier. Accepts a size configuration, then a serial valid/ready stream of A elements followed by B elements in row-major order. Assembles them into the flattened MAX_SIZE×MAX_SIZE buses the multiplier consumes, and holds those buses stable until the consumer acknowledges.

## Interface
- MAX_SIZE, 10: maximum matrix dimension; must match the multiplier.
- DATA_WIDTH, 32: element width; must match the multiplier.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  size request valid.
- cfg_size  input  32  requested dimension n.
- cfg_ready  output  1  high only in IDLE.
- cfg_err  output  1  one-cycle pulse when a request is rejected.
- in_valid  input  1  element valid.
- in_data  input  DATA_WIDTH  element value.
- in_ready  output  1  high in LOAD_A and LOAD_B.
- A  output  MAX_SIZE*MAX_SIZE*DATA_WIDTH  flattened A; element (i,j) at bits ((i*MAX_SIZE+j)*DATA_WIDTH) +: DATA_WIDTH.
- B  output  MAX_SIZE*MAX_SIZE*DATA_WIDTH  flattened B; same layout as A.
- matrix_size  output  32  latched n; feeds the multiplier.
- out_valid  output  1  A, B and matrix_size are complete and stable.
- out_ack  input  1  consumer has captured the result and releases the loader.

## Operation
- States: IDLE, LOAD_A, LOAD_B, DONE.
- IDLE:
  - On a cfg_valid handshake with 1 ≤ cfg_size ≤ MAX_SIZE: latch matrix_size = cfg_size, clear the A and B registers to 0, reset the row and col counters to 0, then go to LOAD_A.
  - On a cfg_valid handshake with cfg_size = 0 or cfg_size > MAX_SIZE: pulse cfg_err for one cycle, stay in IDLE, and leave matrix_size, A and B unchanged.
- LOAD_A and LOAD_B:
  - Each in_valid&&in_ready handshake writes in_data to element (row,col) of the current matrix.
  - col increments; when col = n-1 it wraps to 0 and row increments.
  - Positions with row ≥ n or col ≥ n are never written and stay 0.
- On the handshake for element (n-1,n-1):
  - In LOAD_A: go to LOAD_B with row and col reset to 0.
  - In LOAD_B: go to DONE.
- DONE: out_valid = 1, and A, B and matrix_size are frozen. On out_ack, go to IDLE next cycle.
- out_ack is ignored outside DONE.
- cfg_valid is ignored outside IDLE, because cfg_ready = 0 there.
- in_valid with in_ready = 0 is ignored and no data is consumed.
- Counters are wide enough for MAX_SIZE-1. All arithmetic is unsigned.

## Timing
- Reset values (asynchronous, take effect immediately):
  - state = IDLE
  - A = 0, B = 0, matrix_size = 0
  - out_valid = 0, cfg_err = 0
  - cfg_ready = 1, in_ready = 0
- cfg_ready, in_ready and out_valid are decoded from registered state only. There is no combinational input-to-output path.
- Config handshake at cycle t puts the block in LOAD_A at t+1, so in_ready = 1 at t+1.
- Element writes are visible on A or B the cycle after their handshake.
- Throughput is one element per cycle while in_valid is held high.
- For a final B handshake at cycle t, out_valid = 1 from t+1.
- Minimum latency from the config handshake to out_valid is 2n²+1 cycles.
- For out_ack sampled high at cycle t in DONE:
  - out_valid = 0 and cfg_ready = 1 at t+1.
  - A, B and matrix_size keep their values until the next accepted config.
- cfg_err is asserted in the cycle after the rejected handshake.
- Stalls: in_valid low for any number of cycles holds the counters and the state.
- Reset mid-load aborts the load. All registers return to their reset values and no partial out_valid is produced.

## Test plan
- n=2, stream A=1,2,3,4 then B=5,6,7,8 with no gaps → out_valid at cycle 9 after config; A(0,0..1)=1,2 and A(1,0..1)=3,4; all other elements 0; downstream C(0,0)=19, C(1,1)=50.
- n=MAX_SIZE=10, 200 elements with random in_valid gaps → all 100 positions of each matrix are correct; out_valid only after the 200th handshake.
- cfg_size=0, then cfg_size=11 → one cfg_err pulse each; state stays IDLE; in_ready stays 0; matrix_size is unchanged.
- n=1, A=7, B=6 → out_valid at cycle 3; only element (0,0) is non-zero; out_ack → IDLE next cycle, and a second n=3 load zeroes the stale data.
- rst asserted after 3 A elements at n=3 → immediate return to IDLE with A=0; a fresh n=3 load then completes correctly.
- Hold out_ack low for 20 cycles in DONE while toggling in_valid and cfg_valid → outputs stay frozen, in_ready=0, cfg_ready=0.
